// File: rtl/dot_product_reader_pkg.sv
// ---------------------------------------------------------------------------
// dot_pkg
// Shared definitions for the dot-product read sequencer: the sequencer FSM
// state encoding, the default datapath widths, and a helper that sizes the
// accumulator so a full-length vector of maximum-valued elements cannot
// overflow it.
// ---------------------------------------------------------------------------
package dot_pkg;

   // Sequencer states: wait for start, stream reads, absorb the last
   // returned pair, then publish the result for one cycle.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int ADDR_WIDTH_DEF = 4;
   localparam int DATA_WIDTH_DEF = 8;

   // Each product needs 2*dataWidth bits and up to 2^addrWidth of them are
   // summed, which adds addrWidth bits of headroom.
   function automatic int accWidth(input int dataWidth, input int addrWidth);
      return 2 * dataWidth + addrWidth;
   endfunction

   localparam int ACC_WIDTH_DEF = accWidth(DATA_WIDTH_DEF, ADDR_WIDTH_DEF);

endpackage

// File: rtl/dot_product_reader_if.sv
// ---------------------------------------------------------------------------
// dot_product_reader_if
// Bundles the control handshake (start/base_addr/len -> result/result_valid/
// busy) and the shared vector-memory read port (rd_en/rd_addr -> a_data/
// b_data) of the dot-product read sequencer.
//   slave  : the sequencer itself
//   master : the surrounding control logic and the two vector RAMs
// ---------------------------------------------------------------------------
interface dot_product_reader_if
   import dot_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ACC_WIDTH  = ACC_WIDTH_DEF
);

   logic                  start;
   logic [ADDR_WIDTH-1:0] base_addr;
   logic [ADDR_WIDTH:0]   len;
   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH-1:0] a_data;
   logic [DATA_WIDTH-1:0] b_data;
   logic [ACC_WIDTH-1:0]  result;
   logic                  result_valid;
   logic                  busy;

   modport slave (
      input  start, base_addr, len, a_data, b_data,
      output rd_en, rd_addr, result, result_valid, busy
   );

   modport master (
      output start, base_addr, len, a_data, b_data,
      input  rd_en, rd_addr, result, result_valid, busy
   );

endinterface

// File: rtl/dot_product_reader_mac.sv
// ---------------------------------------------------------------------------
// dp_mac
// Registered unsigned multiply-accumulate used by the dot-product reader.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   clr        : zero the accumulator (wins over en)
//   en         : add a*b into the accumulator this cycle
//   a, b       : unsigned element pair
//   acc        : accumulator register
// ---------------------------------------------------------------------------
module dp_mac
   import dot_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  en,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [ACC_WIDTH-1:0]  acc
);

   logic [2*DATA_WIDTH-1:0] product;
   logic [ACC_WIDTH-1:0]    acc_q;
   logic [ACC_WIDTH-1:0]    acc_d;

   // Full-width unsigned product, zero-extended (or wrapped) into the
   // accumulator width; the sum itself wraps modulo 2^ACC_WIDTH.
   always_comb begin
      product = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
      acc_d   = acc_q;
      if (clr) begin
         acc_d = '0;
      end else if (en) begin
         acc_d = acc_q + ACC_WIDTH'(product);
      end
   end

   // Accumulator register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/dot_product_reader.sv
// ---------------------------------------------------------------------------
// dot_product_reader
// Read-side sequencer for the dot-product datapath. On an accepted start it
// streams N = min(len, 2^ADDR_WIDTH) consecutive (wrapping) addresses into
// the A and B vector RAMs, multiply-accumulates the pairs they return one
// cycle later, and publishes the sum with a one-cycle result_valid pulse.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : slave side of dot_product_reader_if (control handshake plus
//           the shared memory read port)
// ---------------------------------------------------------------------------
module dot_product_reader
   import dot_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
   input logic                  clk,
   input logic                  rst_n,
   dot_product_reader_if.slave  bus
);

   localparam logic [ADDR_WIDTH:0] MAX_LEN  = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] LEN_ZERO = '0;
   localparam logic [ADDR_WIDTH:0] LEN_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] rdAddr_q, rdAddr_d;
   logic [ADDR_WIDTH:0]   remain_q, remain_d;
   logic                  rdEn_q, rdEn_d;
   logic                  dataValid_q;
   logic                  busy_q, busy_d;
   logic                  resultValid_q, resultValid_d;
   logic [ACC_WIDTH-1:0]  result_q, result_d;
   logic [ADDR_WIDTH:0]   clampedLen;
   logic                  accept;
   logic [ACC_WIDTH-1:0]  macAcc;

   // Next-state and next-output logic. remain_q counts reads still to be
   // issued, so the READ state ends on the cycle it issues the last one.
   always_comb begin
      state_d       = state_q;
      rdAddr_d      = rdAddr_q;
      remain_d      = remain_q;
      rdEn_d        = 1'b0;
      accept        = 1'b0;
      clampedLen    = (bus.len > MAX_LEN) ? MAX_LEN : bus.len;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               accept = 1'b1;
               if (clampedLen == LEN_ZERO) begin
                  state_d = DONE;
               end else begin
                  state_d  = READ;
                  rdEn_d   = 1'b1;
                  rdAddr_d = bus.base_addr;
                  remain_d = clampedLen;
               end
            end
         end
         READ: begin
            remain_d = remain_q - LEN_ONE;
            if (remain_q == LEN_ONE) begin
               state_d = DRAIN;
            end else begin
               rdEn_d   = 1'b1;
               rdAddr_d = rdAddr_q + 1'b1;
            end
         end
         DRAIN: begin
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d        = (state_d != IDLE);
      resultValid_d = (state_d == DONE);
      result_d      = (state_q == DONE) ? macAcc : result_q;
   end

   // State, counters, registered outputs and the one-cycle read-enable delay
   // that marks when the RAMs' registered data_out carries a fresh pair.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         rdAddr_q      <= '0;
         remain_q      <= '0;
         rdEn_q        <= 1'b0;
         dataValid_q   <= 1'b0;
         busy_q        <= 1'b0;
         resultValid_q <= 1'b0;
         result_q      <= '0;
      end else begin
         state_q       <= state_d;
         rdAddr_q      <= rdAddr_d;
         remain_q      <= remain_d;
         rdEn_q        <= rdEn_d;
         dataValid_q   <= rdEn_q;
         busy_q        <= busy_d;
         resultValid_q <= resultValid_d;
         result_q      <= result_d;
      end
   end

   dp_mac #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
   ) uMac (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (accept),
      .en    (dataValid_q),
      .a     (bus.a_data),
      .b     (bus.b_data),
      .acc   (macAcc)
   );

   // The final accumulation lands at the end of DRAIN, so during the DONE
   // cycle the sum is only available in the accumulator register itself.
   // The result is therefore steered from the accumulator while the pulse is
   // up and from the holding register afterwards; both sources are flops.
   assign bus.rd_en        = rdEn_q;
   assign bus.rd_addr      = rdAddr_q;
   assign bus.busy         = busy_q;
   assign bus.result_valid = resultValid_q;
   assign bus.result       = resultValid_q ? macAcc : result_q;

endmodule

// File: tb/tb_dot_product_reader.sv
// ---------------------------------------------------------------------------
// tb_dot_product_reader
// Directed bench for dot_product_reader: models the two registered-output
// vector RAMs and checks the cycle-by-cycle read stream, busy, result and
// result_valid against hand-computed values.
// ---------------------------------------------------------------------------
module tb_dot_product_reader;
   import dot_pkg::*;

   localparam int AW   = 4;
   localparam int DW   = 8;
   localparam int AccW = 20;

   logic clk = 1'b0;
   logic rst_n;

   int checkCount = 0;
   int failCount  = 0;

   logic [DW-1:0] memA [16];
   logic [DW-1:0] memB [16];

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   dot_product_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACC_WIDTH(AccW)) bus ();

   dot_product_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACC_WIDTH(AccW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Vector RAM model: data_out is registered and holds when not read.
   always @(posedge clk) begin
      if (bus.rd_en) begin
         bus.a_data <= memA[bus.rd_addr];
         bus.b_data <= memB[bus.rd_addr];
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Advance one cycle and settle just after the active edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present start for one cycle (cycle 0); returns positioned in cycle 1.
   task automatic applyStimulus(input logic [AW-1:0] base, input logic [AW:0] len);
      bus.start     = 1'b1;
      bus.base_addr = base;
      bus.len       = len;
      step();
      bus.start     = 1'b0;
      bus.base_addr = '0;
      bus.len       = '0;
   endtask

   task automatic fillMem(input logic [DW-1:0] value);
      for (int i = 0; i < 16; i++) begin
         memA[i] = value;
         memB[i] = value;
      end
   endtask

   // Run one vector of n>=1 elements and check every cycle 1..n+3.
   task automatic runVector(input string tag, input logic [AW-1:0] base,
                            input logic [AW:0] len, input int n, input int expResult);
      logic [AW-1:0] expAddr;
      applyStimulus(base, len);
      for (int k = 1; k <= n + 2; k++) begin
         expAddr = base + AW'(k - 1);
         checkOutput($sformatf("%s rd_en c%0d", tag, k), 32'(bus.rd_en), 32'(k <= n));
         if (k <= n)
            checkOutput($sformatf("%s rd_addr c%0d", tag, k), 32'(bus.rd_addr), 32'(expAddr));
         checkOutput($sformatf("%s busy c%0d", tag, k), 32'(bus.busy), 32'd1);
         checkOutput($sformatf("%s result_valid c%0d", tag, k), 32'(bus.result_valid),
                     32'(k == n + 2));
         if (k == n + 2)
            checkOutput($sformatf("%s result", tag), 32'(bus.result), 32'(expResult));
         step();
      end
      checkOutput($sformatf("%s busy after", tag), 32'(bus.busy), 32'd0);
      checkOutput($sformatf("%s result_valid after", tag), 32'(bus.result_valid), 32'd0);
      checkOutput($sformatf("%s result held", tag), 32'(bus.result), 32'(expResult));
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.start     = 1'b0;
      bus.base_addr = '0;
      bus.len       = '0;
      fillMem(8'd0);
      step();
      step();

      // Reset state.
      checkOutput("reset rd_en", 32'(bus.rd_en), 32'd0);
      checkOutput("reset rd_addr", 32'(bus.rd_addr), 32'd0);
      checkOutput("reset result", 32'(bus.result), 32'd0);
      checkOutput("reset result_valid", 32'(bus.result_valid), 32'd0);
      checkOutput("reset busy", 32'(bus.busy), 32'd0);
      rst_n = 1'b1;
      step();

      // 1+4+9+16 = 30.
      for (int i = 0; i < 4; i++) begin
         memA[i] = DW'(i + 1);
         memB[i] = DW'(i + 1);
      end
      runVector("basic", 4'd0, 5'd4, 4, 30);

      // 16 * 255*255 = 1040400.
      fillMem(8'd255);
      runVector("full", 4'd0, 5'd16, 16, 1040400);

      // Wrapping addresses 14,15,0,1: 4+9+16+25 = 54.
      fillMem(8'd0);
      memA[14] = 8'd2; memB[14] = 8'd2;
      memA[15] = 8'd3; memB[15] = 8'd3;
      memA[0]  = 8'd4; memB[0]  = 8'd4;
      memA[1]  = 8'd5; memB[1]  = 8'd5;
      runVector("wrap", 4'd14, 5'd4, 4, 54);

      // Zero length: result 0 with the pulse in cycle 1, no reads.
      applyStimulus(4'd3, 5'd0);
      checkOutput("len0 rd_en c1", 32'(bus.rd_en), 32'd0);
      checkOutput("len0 busy c1", 32'(bus.busy), 32'd1);
      checkOutput("len0 result_valid c1", 32'(bus.result_valid), 32'd1);
      checkOutput("len0 result", 32'(bus.result), 32'd0);
      step();
      checkOutput("len0 rd_en c2", 32'(bus.rd_en), 32'd0);
      checkOutput("len0 busy c2", 32'(bus.busy), 32'd0);
      checkOutput("len0 result_valid c2", 32'(bus.result_valid), 32'd0);

      // len=31 clamps to 16 reads, base 5 .. 4 wrapping.
      fillMem(8'd255);
      runVector("clamp", 4'd5, 5'd31, 16, 1040400);

      // start held high: accepts at cycles 0,5,10; pulses at 4,9,14; 3*3+3*3=18.
      fillMem(8'd0);
      memA[0] = 8'd3; memB[0] = 8'd3;
      memA[1] = 8'd3; memB[1] = 8'd3;
      bus.start     = 1'b1;
      bus.base_addr = 4'd0;
      bus.len       = 5'd2;
      for (int c = 0; c < 15; c++) begin
         checkOutput($sformatf("held busy c%0d", c), 32'(bus.busy), 32'((c % 5) != 0));
         checkOutput($sformatf("held rd_en c%0d", c), 32'(bus.rd_en),
                     32'(((c % 5) == 1) || ((c % 5) == 2)));
         checkOutput($sformatf("held result_valid c%0d", c), 32'(bus.result_valid),
                     32'((c % 5) == 4));
         if ((c % 5) == 4)
            checkOutput($sformatf("held result c%0d", c), 32'(bus.result), 32'd18);
         step();
      end
      bus.start = 1'b0;
      step();
      step();
      step();

      // Reset in cycle 3 of a len=8 run, then a clean rerun.
      fillMem(8'd0);
      for (int i = 0; i < 4; i++) begin
         memA[i] = DW'(i + 1);
         memB[i] = DW'(i + 1);
      end
      for (int i = 4; i < 8; i++) begin
         memA[i] = 8'd9;
         memB[i] = 8'd9;
      end
      applyStimulus(4'd0, 5'd8);
      step();
      step();
      rst_n = 1'b0;
      step();
      checkOutput("midreset rd_en", 32'(bus.rd_en), 32'd0);
      checkOutput("midreset rd_addr", 32'(bus.rd_addr), 32'd0);
      checkOutput("midreset result", 32'(bus.result), 32'd0);
      checkOutput("midreset result_valid", 32'(bus.result_valid), 32'd0);
      checkOutput("midreset busy", 32'(bus.busy), 32'd0);
      rst_n = 1'b1;
      step();
      runVector("rerun", 4'd0, 5'd4, 4, 30);

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
